eth_frame_source: RTL and testbench
===================================

# eth_frame_source

Single-buffer Layer-2 frame source sitting directly upstream of the L2 output path: one instance feeds one scheduler channel (Val/SoF/EoF/Req/Data plus ReqConfirm). Accepts a payload byte stream from local logic, buffers one complete frame, requests the channel, then streams the Ethernet header, payload and optional zero padding. Preamble, SFD and FCS are added downstream and are not produced here.

## Interface
- ADDR_W, 11: payload buffer address width; capacity 2^ADDR_W bytes.
- SRC_MAC, 48'h02_00_00_00_00_01: source MAC inserted in header bytes 6..11.
- ETHERTYPE, 16'h88B5: EtherType inserted in header bytes 12..13.
- Clk  in  1  system clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- DstMac  in  48  destination MAC; captured when the frame closes (WrLast accepted).
- WrVal  in  1  payload byte strobe; accepted only while WrReady=1.
- WrData  in  8  payload byte.
- WrLast  in  1  marks the final payload byte; qualified by WrVal.
- WrReady  out  1  buffer accepting payload.
- ReqOut  out  1  channel request to the scheduler.
- ReqConfirm  in  1  channel grant from the scheduler.
- MODE  in  1  0: one byte every 2 clocks; 1: one byte per clock. Sampled at grant, held for the frame.
- ValOut  out  1  byte valid, one-cycle pulse per byte.
- SoFOut  out  1  first byte of frame; only with ValOut.
- EoFOut  out  1  last byte of frame; only with ValOut.
- DataOut  out  8  frame byte.
- ErrOvf  out  1  sticky: a payload exceeded buffer capacity; cleared only by Rst.

## Operation
- States: FILL, REQ, HDR, PAY, PAD; reset enters FILL.
- FILL: WrReady=1; each accepted byte is written at wr_cnt, wr_cnt increments. WrLast accepted -> latch len=wr_cnt+1 and DstMac, enter REQ.
- Overflow: byte accepted with wr_cnt=2^ADDR_W-1 and WrLast=0 -> ErrOvf=1, discard the frame, stay in FILL with WrReady=0 until the next WrLast (inclusive), then wr_cnt=0.
- REQ: WrReady=0, ReqOut=1; held until ReqConfirm sampled high. Grant -> ReqOut=0 next cycle, latch MODE, enter HDR.
- HDR: emit 14 bytes, MSB first: DstMac[47:40]..DstMac[7:0], SRC_MAC likewise, ETHERTYPE[15:8], ETHERTYPE[7:0]. SoFOut on byte 0.
- PAY: emit len bytes from buffer in write order; RAM read is prefetched during HDR so no gap exists at the HDR/PAY boundary.
- PAD: emits 8'h00 until payload+pad = 46 bytes (see Configuration).
- EoFOut on the final emitted byte; next cycle -> FILL, wr_cnt=0, WrReady=1.
- Byte pacing: MODE=1 -> ValOut every cycle; MODE=0 -> ValOut on alternate cycles, low in between; DataOut/SoF/EoF are don't-care while ValOut=0 but held stable.
- WrVal while WrReady=0 is ignored, with no error.

## Timing
- Reset values: WrReady=1, ReqOut=0, ValOut=0, SoFOut=0, EoFOut=0, DataOut=8'h00, ErrOvf=0.
- WrLast accepted at cycle N -> ReqOut=1 at N+1.
- ReqConfirm high at cycle G -> ReqOut=0 and first ValOut (SoF) at G+2.
- Frame emitted bytes: 14+len, or 14+max(len,46) with padding; MODE=0 doubles the span to 2*bytes-1 cycles.
- Rst mid-frame: all outputs take reset values on the next cycle; the buffered frame is lost, and no EoF is produced.
- ReqConfirm outside REQ is ignored.

## Configuration
- ETH_MIN_PAD_EN defined: PAD state present; payload is zero-padded to 46 bytes, so the minimum frame is 60 bytes before FCS.
- ETH_MIN_PAD_EN undefined: PAD state is removed; EoF falls on the last payload byte, with 14+len bytes emitted.

## Structure
- Package eth_pkg: HDR_LEN=14, MIN_PAYLOAD=46, state enum (FILL, REQ, HDR, PAY, PAD), default EtherType constant.
- Sub-module eth_frame_buf: simple dual-port RAM, 2^ADDR_W x 8, one write port, registered read with 1-cycle latency.

## Test plan
- 10-byte payload 01..0A, MODE=1, padding on -> 60 consecutive ValOut pulses; byte0=DstMac[47:40] with SoF; bytes 14..23 = 01..0A; bytes 24..59 = 00; EoF on byte 59.
- 100-byte payload, MODE=0 -> 114 ValOut pulses on alternating cycles, 227 cycles from SoF to EoF; padding inactive.
- ReqConfirm withheld for 50 cycles -> ReqOut held high, ValOut=0, WrReady=0 throughout; grant -> SoF exactly 2 cycles later.
- 2049 bytes without WrLast (ADDR_W=11) -> ErrOvf=1, WrReady=0 until WrLast, no ReqOut; the following 5-byte frame is emitted correctly.
- Rst asserted at emitted byte 20 -> next cycle ValOut=0, ReqOut=0, WrReady=1; a new frame then completes normally.
- Two back-to-back 1500-byte frames, MODE=1 -> each 1514 bytes, with payload matching a byte-wise reference; WrReady returns to 1 the cycle after each EoF.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and FSM state type for the Ethernet frame source.
package eth_pkg;
    localparam int HDR_LEN = 14;
    localparam int MIN_PAYLOAD = 46;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
    typedef enum logic [2:0] {FILL, REQ, HDR, PAY, PAD} state_t;
endpackage

// File: rtl/eth_frame_buf.sv
// eth_frame_buf: simple dual-port byte RAM, one write port, registered read (1-cycle latency).
module eth_frame_buf #(
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/eth_frame_source.sv
// eth_frame_source: buffers one payload, requests the L2 channel, then streams header and payload.
// Define ETH_MIN_PAD_EN to zero-pad payloads shorter than 46 bytes.
module eth_frame_source
    import eth_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [47:0] DstMac,
    input  logic        WrVal,
    input  logic [7:0]  WrData,
    input  logic        WrLast,
    output logic        WrReady,
    output logic        ReqOut,
    input  logic        ReqConfirm,
    input  logic        MODE,
    output logic        ValOut,
    output logic        SoFOut,
    output logic        EoFOut,
    output logic [7:0]  DataOut,
    output logic        ErrOvf
);
    localparam int LW = ADDR_W + 1;
    localparam int PW = ADDR_W + 2;

    state_t            st_q, st_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LW-1:0]     len_q, len_d, pay_len;
    logic [47:0]       dst_q, dst_d;
    logic [PW-1:0]     pos_q, pos_d, nxt, total;
    logic [7:0]        data_q, data_d, hdr_byte, rd_data;
    logic              mode_q, mode_d, drop_q, drop_d, err_q, err_d, gap_q, gap_d;
    logic              val_q, val_d, sof_q, sof_d, eof_q, eof_d;
    logic [111:0]      hdr;
    logic [3:0]        sh;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en, busy, done, emit, last;

    assign WrReady = (st_q == FILL) && !drop_q;
    assign ReqOut  = st_q == REQ;
    assign ValOut  = val_q;
    assign SoFOut  = val_q & sof_q;
    assign EoFOut  = val_q & eof_q;
    assign DataOut = data_q;
    assign ErrOvf  = err_q;

    assign wr_en = WrVal & WrReady;
    assign busy  = st_q inside {HDR, PAY, PAD};
    // Hold the FSM one extra cycle after the last byte so WrReady rises after EoF is seen.
    assign done  = val_q & eof_q;
    assign emit  = busy & ~done & (mode_q | ~gap_q);
`ifdef ETH_MIN_PAD_EN
    assign pay_len = (len_q < LW'(MIN_PAYLOAD)) ? LW'(MIN_PAYLOAD) : len_q;
`else
    assign pay_len = len_q;
`endif
    assign total = PW'(HDR_LEN) + PW'(pay_len);
    assign last  = pos_q == total - PW'(1);
    // Address the byte needed next cycle so the registered RAM read lines up with its emit slot.
    assign nxt      = emit ? pos_q + PW'(1) : pos_q;
    assign rd_addr  = ADDR_W'(nxt - PW'(HDR_LEN));
    assign hdr      = {dst_q, SRC_MAC, ETHERTYPE};
    assign sh       = 4'(HDR_LEN - 1) - pos_q[3:0];
    assign hdr_byte = hdr[{sh, 3'b000} +: 8];

    eth_frame_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk_i  (Clk),
        .we_i   (wr_en),
        .waddr_i(wr_cnt_q),
        .wdata_i(WrData),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    always_comb begin
        st_d = st_q;
        wr_cnt_d = wr_cnt_q;
        len_d = len_q;
        dst_d = dst_q;
        mode_d = mode_q;
        drop_d = drop_q;
        err_d = err_q;
        pos_d = pos_q;
        gap_d = gap_q;
        val_d = 1'b0;
        sof_d = sof_q;
        eof_d = eof_q;
        data_d = data_q;
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            if (WrLast) begin
                len_d = {1'b0, wr_cnt_q} + LW'(1);
                dst_d = DstMac;
                wr_cnt_d = '0;
                st_d = REQ;
            end else if (&wr_cnt_q) begin
                err_d = 1'b1;
                drop_d = 1'b1;
            end
        end
        if (drop_q && WrVal && WrLast) begin
            drop_d = 1'b0;
            wr_cnt_d = '0;
        end
        if (st_q == REQ && ReqConfirm) begin
            st_d = HDR;
            mode_d = MODE;
            pos_d = '0;
            gap_d = 1'b0;
        end
        if (done) st_d = FILL;
        if (emit) begin
            val_d = 1'b1;
            sof_d = pos_q == '0;
            eof_d = last;
            data_d = (st_q == HDR) ? hdr_byte : (st_q == PAY) ? rd_data : 8'h00;
            pos_d = pos_q + PW'(1);
            gap_d = ~mode_q;
            if (st_q == HDR && pos_q == PW'(HDR_LEN - 1)) st_d = PAY;
`ifdef ETH_MIN_PAD_EN
            if (st_q == PAY && !last && pos_q == PW'(HDR_LEN) + PW'(len_q) - PW'(1)) st_d = PAD;
`endif
        end else if (busy) begin
            gap_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_q <= FILL;
            wr_cnt_q <= '0;
            len_q <= '0;
            dst_q <= '0;
            mode_q <= 1'b0;
            drop_q <= 1'b0;
            err_q <= 1'b0;
            pos_q <= '0;
            gap_q <= 1'b0;
            val_q <= 1'b0;
            sof_q <= 1'b0;
            eof_q <= 1'b0;
            data_q <= '0;
        end else begin
            st_q <= st_d;
            wr_cnt_q <= wr_cnt_d;
            len_q <= len_d;
            dst_q <= dst_d;
            mode_q <= mode_d;
            drop_q <= drop_d;
            err_q <= err_d;
            pos_q <= pos_d;
            gap_q <= gap_d;
            val_q <= val_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
            data_q <= data_d;
        end
    end
endmodule

// File: tb/tb_eth_frame_source.sv
// tb_eth_frame_source: randomized scoreboard bench; frames are modelled byte-by-byte from the frame format.
`timescale 1ns/1ps
module tb_eth_frame_source;
    localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam int          HDR_N = 14;
`ifdef ETH_MIN_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    typedef struct packed { logic sof; logic eof; logic [7:0] d; } ebyte_t;

    logic        Clk = 1'b0, Rst = 1'b1, WrVal = 1'b0, WrLast = 1'b0, ReqConfirm = 1'b0, MODE = 1'b0;
    logic [47:0] DstMac = '0;
    logic [7:0]  WrData = '0;
    logic        WrReady, ReqOut, ValOut, SoFOut, EoFOut, ErrOvf;
    logic [7:0]  DataOut;

    ebyte_t exp_q[$];
    ebyte_t e;
    int     vectors = 0, errors = 0, cyc = 0, last_cyc = 0, sof_cyc = 0, eof_cyc = 0;
    bit     cur_mode = 1'b1;

    eth_frame_source dut (
        .Clk(Clk), .Rst(Rst), .DstMac(DstMac), .WrVal(WrVal), .WrData(WrData), .WrLast(WrLast),
        .WrReady(WrReady), .ReqOut(ReqOut), .ReqConfirm(ReqConfirm), .MODE(MODE), .ValOut(ValOut),
        .SoFOut(SoFOut), .EoFOut(EoFOut), .DataOut(DataOut), .ErrOvf(ErrOvf)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every emitted byte is matched against the head of the expected queue.
    always @(negedge Clk) begin
        if (!Rst && ValOut) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", DataOut);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {SoFOut, EoFOut, DataOut}, {e.sof, e.eof, e.d});
                if (!e.sof) chk("pace", cyc - last_cyc, cur_mode ? 1 : 2);
                if (e.sof) sof_cyc = cyc;
                if (e.eof) eof_cyc = cyc;
            end
            last_cyc = cyc;
        end
    end

    task automatic run_frame(input int len, input bit mode, input int hold, input bit inc, input int rst_at);
        logic [7:0]   pay[$];
        ebyte_t       mq[$];
        logic [47:0]  dst;
        logic [111:0] hdr;
        logic [7:0]   d;
        int           nb, n, t;
        bit           bad;
        dst = {16'($urandom), 32'($urandom)};
        for (int i = 0; i < len; i++) pay.push_back(inc ? 8'(i + 1) : 8'($urandom));
        nb = HDR_N + ((PAD_EN && len < 46) ? 46 : len);
        hdr = {dst, SRC, ETYPE};
        for (int k = 0; k < nb; k++) begin
            d = (k < HDR_N) ? hdr[8 * (13 - k) +: 8] : (k < HDR_N + len) ? pay[k - HDR_N] : 8'h00;
            mq.push_back(ebyte_t'{1'(k == 0), 1'(k == nb - 1), d});
        end
        DstMac = dst;
        bad = 1'b0;
        for (int i = 0; i < len;) begin
            @(negedge Clk);
            if (!WrReady) bad = 1'b1;
            ReqConfirm = 1'($urandom);
            MODE = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                WrVal = 1'b0;
                WrLast = 1'($urandom);
                WrData = 8'($urandom);
            end else begin
                WrVal = 1'b1;
                WrData = pay[i];
                WrLast = (i == len - 1);
                if (WrLast) foreach (mq[k]) exp_q.push_back(mq[k]);
                i++;
            end
        end
        chk("wrready_fill", bad, 0);
        @(negedge Clk);
        WrVal = 1'b0;
        WrLast = 1'b0;
        ReqConfirm = 1'b0;
        DstMac = {16'($urandom), 32'($urandom)};
        chk("req_after_last", ReqOut, 1);
        chk("wrready_in_req", WrReady, 0);
        bad = 1'b0;
        repeat (hold) begin
            @(negedge Clk);
            WrVal = 1'($urandom);
            WrData = 8'($urandom);
            if (!ReqOut || ValOut || WrReady) bad = 1'b1;
        end
        if (hold > 0) chk("req_hold", bad, 0);
        WrVal = 1'b0;
        ReqConfirm = 1'b1;
        MODE = mode;
        cur_mode = mode;
        @(negedge Clk);
        ReqConfirm = 1'b0;
        MODE = ~mode;
        chk("req_drop_after_grant", ReqOut, 0);
        chk("no_val_before_sof", ValOut, 0);
        @(negedge Clk);
        chk("sof_two_after_grant", {ValOut, SoFOut}, 2'b11);
        n = 0;
        t = 0;
        forever begin
            if (ValOut) begin
                if (n == rst_at) begin
                    Rst = 1'b1;
                    WrVal = 1'b0;
                    WrLast = 1'b0;
                    ReqConfirm = 1'b0;
                    @(negedge Clk);
                    chk("rst_outputs", {ValOut, SoFOut, EoFOut, ReqOut, WrReady, ErrOvf, DataOut}, {6'b000010, 8'h00});
                    Rst = 1'b0;
                    exp_q.delete();
                    return;
                end
                if (EoFOut) break;
                n++;
            end
            if (++t > 8000) begin
                vectors++;
                errors++;
                $display("FAIL eof_timeout: no EoF after %0d cycles", t);
                exp_q.delete();
                return;
            end
            @(negedge Clk);
            WrVal = 1'($urandom);
            WrData = 8'($urandom);
            WrLast = 1'($urandom);
            ReqConfirm = 1'($urandom);
            MODE = 1'($urandom);
        end
        WrVal = 1'b0;
        WrLast = 1'b0;
        ReqConfirm = 1'b0;
        chk("byte_count", n + 1, nb);
        @(negedge Clk);
        chk("wrready_after_eof", {WrReady, ValOut, ReqOut}, 3'b100);
        chk("frame_span", eof_cyc - sof_cyc + 1, mode ? nb : 2 * nb - 1);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_overflow();
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 2049; i++) begin
            @(negedge Clk);
            if (i == 2047) chk("pre_ovf", {ErrOvf, WrReady}, 2'b01);
            WrVal = 1'b1;
            WrData = 8'($urandom);
            WrLast = 1'b0;
            ReqConfirm = 1'($urandom);
        end
        @(negedge Clk);
        WrVal = 1'b0;
        ReqConfirm = 1'b0;
        chk("ovf_flag", {ErrOvf, WrReady, ReqOut}, 3'b100);
        repeat (10) begin
            @(negedge Clk);
            WrVal = 1'($urandom);
            WrLast = 1'b0;
            ReqConfirm = 1'($urandom);
            if (WrReady || ReqOut || !ErrOvf) bad = 1'b1;
        end
        chk("ovf_discard", bad, 0);
        @(negedge Clk);
        WrVal = 1'b1;
        WrLast = 1'b1;
        ReqConfirm = 1'b0;
        @(negedge Clk);
        WrVal = 1'b0;
        WrLast = 1'b0;
        chk("ovf_release", {ErrOvf, WrReady, ReqOut}, 3'b110);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_wrready", WrReady, 1);
        chk("rst_reqout", ReqOut, 0);
        chk("rst_val_sof_eof", {ValOut, SoFOut, EoFOut}, 3'b000);
        chk("rst_data", DataOut, 8'h00);
        chk("rst_errovf", ErrOvf, 0);
        Rst = 1'b0;
        run_frame(10, 1'b1, 0, 1'b1, -1);
        run_frame(100, 1'b0, 3, 1'b0, -1);
        run_frame(20, 1'b1, 50, 1'b0, -1);
        run_frame(45, 1'b1, 1, 1'b0, -1);
        run_frame(46, 1'b0, 0, 1'b0, -1);
        run_frame(2048, 1'b1, 0, 1'b0, -1);
        chk("no_ovf_at_capacity", ErrOvf, 0);
        do_overflow();
        run_frame(5, 1'($urandom), 0, 1'b1, -1);
        chk("ovf_sticky", ErrOvf, 1);
        run_frame(30, 1'($urandom), 0, 1'b0, 20);
        run_frame(12, 1'b1, 0, 1'b1, -1);
        run_frame(1500, 1'b1, 0, 1'b0, -1);
        run_frame(1500, 1'b1, 0, 1'b0, -1);
        repeat (8) run_frame($urandom_range(1, 80), 1'($urandom), $urandom_range(0, 4), 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
